single_mem_ctrl: RTL and testbench

- Multi-cycle controller for the CPU's single unified memory, directly downstream of the CPU core.
- Arbitrates between the instruction-fetch channel and the data (load/store) channel.
- Applies a programmable number of wait states, then performs byte, halfword or word accesses selected by funct3 against an internal little-endian byte array.
- Returns each result on a one-cycle acknowledge pulse, so the core can stall on memory instead of relying on clock-phase multiplexing.

---
 rtl/single_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_single_mem_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/single_mem_ctrl.sv
// Multi-cycle controller for a unified instruction/data byte memory: round-robin arbitration,
// LATENCY wait states and funct3-sized little-endian accesses. Optional macro: SINGLE_MEM_MISALIGN_TRAP_EN.
module single_mem_ctrl #(
    parameter int DEPTH_BYTES = 4096,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef SINGLE_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;
    typedef enum logic {CH_FETCH, CH_DATA} chan_e;

    state_e         state;
    chan_e          chan;
    chan_e          last_grant;
    logic [3:0]     cnt;
    logic [AW-1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic           we_q;
    logic [2:0]     funct3_q;

    logic [7:0]     mem [DEPTH_BYTES];

    logic           grant_data;
    logic [31:0]    rd_word;
    logic [31:0]    rd_ext;
    logic           misaligned;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:AW], d_addr[31:AW]};
    assign busy             = (state != IDLE);

    // With both channels pending, serve the one that was not served last.
    assign grant_data = d_req && (!if_req || last_grant == CH_FETCH);

    // Index arithmetic is AW bits wide, so multi-byte accesses wrap at the top of the array.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        rd_ext     = '0;
        misaligned = 1'b0;
        rd_word    = {mem[addr_q + AW'(3)], mem[addr_q + AW'(2)],
                      mem[addr_q + AW'(1)], mem[addr_q]};
        case (funct3_q[1:0])
            2'b00:   rd_ext = funct3_q[2] ? {24'b0, rd_word[7:0]}
                                          : {{24{rd_word[7]}}, rd_word[7:0]};
            2'b01:   rd_ext = funct3_q[2] ? {16'b0, rd_word[15:0]}
                                          : {{16{rd_word[15]}}, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
        if (TRAP_EN)
            misaligned = (funct3_q[1:0] == 2'b01 && addr_q[0]) ||
                         (funct3_q[1] && addr_q[1:0] != 2'b00);
    end

    // NOTE: the byte array has no reset; its contents are meant to survive rst and a reset
    // network over every storage bit would prevent mapping it onto a RAM.
    always_ff @(posedge clk) begin
        if (state == ACCESS && chan == CH_DATA && we_q && !misaligned) begin
            mem[addr_q] <= wdata_q[7:0];
            if (funct3_q[1:0] != 2'b00)
                mem[addr_q + AW'(1)] <= wdata_q[15:8];
            if (funct3_q[1]) begin
                mem[addr_q + AW'(2)] <= wdata_q[23:16];
                mem[addr_q + AW'(3)] <= wdata_q[31:24];
            end
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            chan       <= CH_FETCH;
            last_grant <= CH_FETCH;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        if (grant_data) begin
                            chan     <= CH_DATA;
                            addr_q   <= d_addr[AW-1:0];
                            we_q     <= d_we;
                            wdata_q  <= d_wdata;
                            funct3_q <= d_funct3;
                        end else begin
                            chan     <= CH_FETCH;
                            addr_q   <= if_addr[AW-1:0];
                            we_q     <= 1'b0;
                            funct3_q <= 3'b010;
                        end
                        cnt   <= 4'(LATENCY);
                        state <= (LATENCY > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= ACCESS;
                end
                ACCESS: begin
                    last_grant <= chan;
                    if (chan == CH_DATA) begin
                        d_ack <= 1'b1;
                        d_err <= misaligned;
                        if (!we_q)
                            d_rdata <= misaligned ? '0 : rd_ext;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= misaligned ? NOP : rd_word;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    d_err  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_single_mem_ctrl.sv
// Directed bench for single_mem_ctrl: three instances with LATENCY 2, 0 and 4 share clock and reset.
module tb_single_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req   [3];
    logic [31:0] if_addr  [3];
    logic        if_ack   [3];
    logic [31:0] if_rdata [3];
    logic        d_req    [3];
    logic        d_we     [3];
    logic [31:0] d_addr   [3];
    logic [31:0] d_wdata  [3];
    logic [2:0]  d_funct3 [3];
    logic        d_ack    [3];
    logic [31:0] d_rdata  [3];
    logic        d_err    [3];
    logic        busy     [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        single_mem_ctrl #(
            .DEPTH_BYTES(4096),
            .LATENCY    (g == 0 ? 2 : (g == 1 ? 0 : 4))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_ack   (if_ack[g]),
            .if_rdata (if_rdata[g]),
            .d_req    (d_req[g]),
            .d_we     (d_we[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_funct3 (d_funct3[g]),
            .d_ack    (d_ack[g]),
            .d_rdata  (d_rdata[g]),
            .d_err    (d_err[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with the instance idle; returns at posedge+1 with it idle again.
    task automatic d_access(input int k, input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata, input logic exp_err,
                            output logic [31:0] rdata, output int cycles);
        d_we[k] = we; d_funct3[k] = f3; d_addr[k] = addr; d_wdata[k] = wdata; d_req[k] = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!d_ack[k] && cycles < 40);
        d_req[k] = 1'b0;
        rdata = d_rdata[k];
        check({tag, "_ack"}, 32'(d_ack[k]), 32'd1);
        check({tag, "_err"}, 32'(d_err[k]), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic fetch(input int k, input string tag, input logic [31:0] addr,
                         output logic [31:0] rdata, output int cycles);
        if_addr[k] = addr; if_req[k] = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!if_ack[k] && cycles < 40);
        if_req[k] = 1'b0;
        rdata = if_rdata[k];
        check({tag, "_ack"}, 32'(if_ack[k]), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          ack_cyc [$];
        int          ack_ch  [$];
        logic        seen;

        for (int k = 0; k < 3; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            d_addr[k] = '0; d_wdata[k] = '0; d_funct3[k] = '0;
        end

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_if_ack", 32'(if_ack[0]), 32'd0);
        check("rst_d_ack", 32'(d_ack[0]), 32'd0);
        check("rst_if_rdata", if_rdata[0], 32'd0);
        check("rst_d_rdata", d_rdata[0], 32'd0);
        check("rst_d_err", 32'(d_err[0]), 32'd0);

        // Arbitration on the LATENCY = 0 instance: both raised together, DATA first.
        if_addr[1] = 32'h0; d_addr[1] = 32'h100; d_funct3[1] = 3'b010; d_we[1] = 1'b0;
        if_req[1] = 1'b1; d_req[1] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (d_ack[1])  begin ack_cyc.push_back(c); ack_ch.push_back(0); end
            if (if_ack[1]) begin ack_cyc.push_back(c); ack_ch.push_back(1); end
            if (d_ack[1] && if_ack[1]) check("arb_ack_exclusive", 32'd1, 32'd0);
        end
        if_req[1] = 1'b0; d_req[1] = 1'b0;
        check("arb_ack_count", 32'(ack_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
            check($sformatf("arb_chan%0d", i), 32'(ack_ch[i]), 32'(i % 2));
            check($sformatf("arb_cyc%0d", i), 32'(ack_cyc[i]), 32'(2 + 3 * i));
        end
        @(posedge clk); #1;

        // Store/load patterns on the LATENCY = 2 instance.
        d_access(0, "sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, rd, cyc);
        check("sw_100_latency", 32'(cyc), 32'd4);
        d_access(0, "lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rd, cyc);
        check("lw_100", rd, 32'hDEADBEEF);
        check("lw_100_latency", 32'(cyc), 32'd4);
        d_access(0, "lbu_101", 1'b0, 3'b100, 32'h101, 32'h0, 1'b0, rd, cyc);
        check("lbu_101", rd, 32'h000000BE);
        d_access(0, "lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, rd, cyc);
        check("lb_103", rd, 32'hFFFFFFDE);
        d_access(0, "lh_102", 1'b0, 3'b001, 32'h102, 32'h0, 1'b0, rd, cyc);
        check("lh_102", rd, 32'hFFFFDEAD);
        d_access(0, "lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 1'b0, rd, cyc);
        check("lhu_102", rd, 32'h0000DEAD);
        d_access(0, "lw_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 1'b0, rd, cyc);
        check("lw_f3_011", rd, 32'hDEADBEEF);

        d_access(0, "sw_200", 1'b1, 3'b010, 32'h200, 32'h11223344, 1'b0, rd, cyc);
        d_access(0, "sb_200", 1'b1, 3'b000, 32'h200, 32'hAAAAAA7F, 1'b0, rd, cyc);
        d_access(0, "lw_200", 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, rd, cyc);
        check("lw_200_after_sb", rd, 32'h1122337F);
        d_access(0, "sh_202", 1'b1, 3'b001, 32'h202, 32'h5555CAFE, 1'b0, rd, cyc);
        check("sh_keeps_d_rdata", rd, 32'h1122337F);
        d_access(0, "lw_200b", 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, rd, cyc);
        check("lw_200_after_sh", rd, 32'hCAFE337F);

        fetch(0, "if_100", 32'h100, rd, cyc);
        check("if_100", rd, 32'hDEADBEEF);
        check("if_100_latency", 32'(cyc), 32'd4);

        // Wrap at the top of the array.
        d_access(0, "sw_000", 1'b1, 3'b010, 32'h000, 32'h01020304, 1'b0, rd, cyc);
`ifdef SINGLE_MEM_MISALIGN_TRAP_EN
        d_access(0, "sw_ffe", 1'b1, 3'b010, 32'hFFE, 32'hA1B2C3D4, 1'b1, rd, cyc);
        check("sw_ffe_latency", 32'(cyc), 32'd4);
        fetch(0, "if_1000", 32'h1000, rd, cyc);
        check("if_1000", rd, 32'h01020304);
        d_access(0, "lw_102_mis", 1'b0, 3'b010, 32'h102, 32'h0, 1'b1, rd, cyc);
        check("lw_102_mis_rdata", rd, 32'h0);
        fetch(0, "if_101_mis", 32'h101, rd, cyc);
        check("if_101_nop", rd, 32'h00000013);
`else
        d_access(0, "sw_ffe", 1'b1, 3'b010, 32'hFFE, 32'hA1B2C3D4, 1'b0, rd, cyc);
        d_access(0, "lbu_ffe", 1'b0, 3'b100, 32'hFFE, 32'h0, 1'b0, rd, cyc);
        check("lbu_ffe", rd, 32'h000000D4);
        d_access(0, "lbu_fff", 1'b0, 3'b100, 32'hFFF, 32'h0, 1'b0, rd, cyc);
        check("lbu_fff", rd, 32'h000000C3);
        d_access(0, "lbu_000", 1'b0, 3'b100, 32'h000, 32'h0, 1'b0, rd, cyc);
        check("lbu_000", rd, 32'h000000B2);
        d_access(0, "lbu_001", 1'b0, 3'b100, 32'h001, 32'h0, 1'b0, rd, cyc);
        check("lbu_001", rd, 32'h000000A1);
        d_access(0, "lhu_fff", 1'b0, 3'b101, 32'hFFF, 32'h0, 1'b0, rd, cyc);
        check("lhu_fff_wrap", rd, 32'h0000B2C3);
        fetch(0, "if_1000", 32'h1000, rd, cyc);
        check("if_1000", rd, 32'h0102A1B2);
`endif

        // Reset during WAIT on the LATENCY = 4 instance.
        d_access(2, "sw_40", 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 1'b0, rd, cyc);
        check("sw_40_latency", 32'(cyc), 32'd6);
        d_we[2] = 1'b1; d_funct3[2] = 3'b010; d_addr[2] = 32'h40; d_wdata[2] = 32'h55;
        d_req[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstwait_busy_pre", 32'(busy[2]), 32'd1);
        rst = 1'b0; d_req[2] = 1'b0;
        #2 rst = 1'b1;
        check("rstwait_busy_post", 32'(busy[2]), 32'd0);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (d_ack[2]) seen = 1'b1;
        end
        check("rstwait_no_ack", 32'(seen), 32'd0);
        d_access(2, "lw_40", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, rd, cyc);
        check("lw_40_prior", rd, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
